gpio_edge_irq: RTL and testbench
================================

GPIO_EDGE_IRQ -- requirements
Module: gpio_edge_irq

Interface
REQ-001 Parameter N_IN, default 4: number of input channels, legal range 1..32.
REQ-002 Parameter N_OUT, default 1: number of output bits, legal range 1..32.
REQ-003 Parameter DEBOUNCE, default 4: number of consecutive stable samples needed to accept a new input level, legal range 1..65535.
REQ-004 clk  in  1  single clock; every flop is clocked on the rising edge.
REQ-005 rst  in  1  synchronous reset, active high.
REQ-006 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone slave cycle, strobe and write-enable.
REQ-007 wb_adr_i  in  32  byte address; only bits [4:2] are decoded.
REQ-008 wb_dat_i  in  32  write data.
REQ-009 wb_sel_i  in  4  byte selects; ignored, every write is full-word.
REQ-010 wb_dat_o  out  32  read data.
REQ-011 wb_ack_o  out  1  Wishbone acknowledge.
REQ-012 gpio_in  in  N_IN  asynchronous input pins.
REQ-013 gpio_out  out  N_OUT  registered output pins.
REQ-014 irq_o  out  1  level interrupt to the CPU.

Function
REQ-015 Each gpio_in bit SHALL pass through a 2-flop synchronizer before any other logic sees it.
REQ-016 Each channel SHALL have a debounce counter that works as follows:
- The counter is sized to hold DEBOUNCE.
- It clears on any cycle where the synced bit equals the debounced bit.
- Otherwise it increments.
- The debounced bit takes the synced value on the edge where the counter would reach DEBOUNCE.
- After that update, the counter clears.
REQ-017 A pin level held steady from before clock edge k SHALL appear in IN at edge k+1+DEBOUNCE (2 synchronizer stages plus DEBOUNCE samples).
REQ-018 A pin excursion shorter than DEBOUNCE synced cycles SHALL change neither IN nor PEND.
REQ-019 Register map (offset, access, content):
- 0x00 IN, RO: debounced levels.
- 0x04 OUT, RW: drives gpio_out.
- 0x08 RISE_EN, RW.
- 0x0C FALL_EN, RW.
- 0x10 PEND, write-1-to-clear.
- 0x14 IRQ_EN, RW, bit 0 only.
REQ-020 Register bits at or above the channel width SHALL read 0 and ignore writes.
REQ-021 Unmapped offsets 0x18–0x1C SHALL read 0, ignore writes, and still be acknowledged.
REQ-022 PEND[i] SHALL set on the edge after debounced[i] goes 0->1 with RISE_EN[i]=1, or goes 1->0 with FALL_EN[i]=1.
REQ-023 When a PEND write-1-to-clear and a new qualifying edge hit the same bit in the same cycle, the set SHALL win and the bit stays 1.
REQ-024 Clearing RISE_EN or FALL_EN SHALL NOT clear bits already set in PEND.
REQ-025 irq_o SHALL be combinational: IRQ_EN[0] AND (OR of all PEND bits).
REQ-026 wb_ack_o SHALL assert exactly one cycle after the first cycle with wb_cyc_i & wb_stb_i & !wb_ack_o.
REQ-027 wb_ack_o SHALL hold for one cycle only; back-to-back accesses therefore cost 2 cycles each.
REQ-028 A write SHALL take effect on the same edge that raises wb_ack_o.
REQ-029 wb_dat_o SHALL be registered and valid while wb_ack_o=1, and SHALL be 0 otherwise.
REQ-030 gpio_out SHALL equal OUT, with bit 0 taken from wb_dat_i[0].

Reset
REQ-031 With rst high at a clock edge, the following SHALL all clear to 0:
- synchronizers, debounce counters, debounced levels;
- OUT, RISE_EN, FALL_EN, PEND, IRQ_EN;
- wb_ack_o and wb_dat_o.
REQ-032 As a result of REQ-031, gpio_out=0 and irq_o=0 from the first edge with rst high.
REQ-033 Reset during a bus access SHALL abort it with no ack; reset during a debounce SHALL discard the partial count.
REQ-034 After rst falls, a pin already held at 1 SHALL enter IN after the normal 2+DEBOUNCE cycles, and SHALL set PEND if RISE_EN was programmed in the meantime.

Verification
REQ-035 Reset check: N_IN=4, set all registers to 1s, pulse rst for 1 cycle -> every register reads 0, gpio_out=0, irq_o=0.
REQ-036 Rising edge: RISE_EN=0x1, IRQ_EN=1, gpio_in 0000->0001 -> IN=0x1 at edge k+5, PEND=0x1 at edge k+6, irq_o=1; then write PEND=0x1 -> irq_o=0.
REQ-037 Glitch rejection: DEBOUNCE=4, gpio_in[1] high for 3 cycles -> IN and PEND stay 0; the same pulse held 4 cycles -> IN[1] toggles.
REQ-038 Fall masking: FALL_EN=0x0, RISE_EN=0xF, walk gpio_in through 0001, 0010, 0100, 1000 (each held 100 cycles) -> PEND=0xF, with no set from any falling edge.
REQ-039 Collision: PEND[2] write-1-to-clear issued on the same edge that PEND[2] would set -> PEND[2] reads 1.
REQ-040 Bus timing: write OUT=0x1 -> gpio_out=1 on the ack edge, wb_ack_o high for exactly 1 cycle; read of offset 0x1C -> returns 0 and is acknowledged.

Source files
------------

// File: rtl/gpio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module   : gpio_edge_irq
// Purpose  : Debounced GPIO inputs with edge-triggered interrupt, Wishbone regs
// Revision : 1.0 - initial release
// ============================================================================
module gpio_edge_irq #(
    parameter int N_IN     = 4,
    parameter int N_OUT    = 1,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [N_IN-1:0]   gpio_in,
    output logic [N_OUT-1:0]  gpio_out,
    output logic              irq_o
);

    localparam int         c_cnt_w    = $clog2(DEBOUNCE + 1);
    localparam logic [2:0] c_adr_in   = 3'd0;
    localparam logic [2:0] c_adr_out  = 3'd1;
    localparam logic [2:0] c_adr_rise = 3'd2;
    localparam logic [2:0] c_adr_fall = 3'd3;
    localparam logic [2:0] c_adr_pend = 3'd4;
    localparam logic [2:0] c_adr_irqe = 3'd5;

    logic [N_IN-1:0]  r_sync1;
    logic [N_IN-1:0]  r_sync2;
    logic [N_IN-1:0]  w_deb;
    logic [N_IN-1:0]  r_deb_d;
    logic [N_IN-1:0]  r_rise_en;
    logic [N_IN-1:0]  r_fall_en;
    logic [N_IN-1:0]  r_pend;
    logic [N_OUT-1:0] r_out;
    logic             r_irq_en;
    logic             r_ack;
    logic [31:0]      r_dat;

    logic             w_acc;
    logic             w_wr;
    logic [2:0]       w_sel;
    logic [31:0]      w_rdata;
    logic [N_IN-1:0]  w_set;
    logic [N_IN-1:0]  w_clr;
    logic             w_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    // A new level is accepted only after DEBOUNCE consecutive differing samples.
    for (genvar g = 0; g < N_IN; g++) begin : g_ch
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_lvl;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_sync2[g] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_w'(DEBOUNCE - 1)) begin
                r_lvl <= r_sync2[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end

        assign w_deb[g] = r_lvl;
    end

    assign w_acc = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr  = w_acc & wb_we_i;
    assign w_sel = wb_adr_i[4:2];

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            c_adr_in:   w_rdata[N_IN-1:0]  = w_deb;
            c_adr_out:  w_rdata[N_OUT-1:0] = r_out;
            c_adr_rise: w_rdata[N_IN-1:0]  = r_rise_en;
            c_adr_fall: w_rdata[N_IN-1:0]  = r_fall_en;
            c_adr_pend: w_rdata[N_IN-1:0]  = r_pend;
            c_adr_irqe: w_rdata[0]         = r_irq_en;
            default:    w_rdata            = '0;
        endcase
    end

    assign w_set = (w_deb & ~r_deb_d & r_rise_en) | (~w_deb & r_deb_d & r_fall_en);
    assign w_clr = (w_wr && (w_sel == c_adr_pend)) ? wb_dat_i[N_IN-1:0] : '0;

    // Set is OR-ed in after the clear so a coincident new edge is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_d   <= '0;
            r_pend    <= '0;
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_irq_en  <= 1'b0;
        end else begin
            r_deb_d <= w_deb;
            r_pend  <= (r_pend & ~w_clr) | w_set;
            if (w_wr) begin
                case (w_sel)
                    c_adr_out:  r_out     <= wb_dat_i[N_OUT-1:0];
                    c_adr_rise: r_rise_en <= wb_dat_i[N_IN-1:0];
                    c_adr_fall: r_fall_en <= wb_dat_i[N_IN-1:0];
                    c_adr_irqe: r_irq_en  <= wb_dat_i[0];
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_acc ? w_rdata : '0;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign gpio_out = r_out;
    assign irq_o    = r_irq_en & (|r_pend);

    assign w_unused = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

endmodule
`default_nettype wire

// File: tb/tb_gpio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_edge_irq
// Purpose  : Scoreboard bench for gpio_edge_irq with a window-based pin model
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_edge_irq;

    localparam int c_nin = 4;
    localparam int c_deb = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [3:0]  gpio_in = '0;
    logic [0:0]  gpio_out;
    logic        irq_o;

    int tests = 0;
    int fails = 0;

    gpio_edge_irq #(.N_IN(c_nin), .N_OUT(1), .DEBOUNCE(c_deb)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [3:0] m_in = '0, m_rise = '0, m_fall = '0, m_pend = '0;
    logic [3:0] m_rflip = '0, m_fflip = '0;
    logic       m_out = 1'b0, m_irqen = 1'b0, m_ack = 1'b0;
    logic [3:0] p1 = '0, p2 = '0;
    logic       r1 = 1'b1, r2 = 1'b1;
    logic [3:0] syn_q[$];
    logic [3:0] mc, mset, mclr;
    logic [31:0] mrd;
    logic       macc, mall;
    exp_t       me;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pin level is accepted once the last DEBOUNCE synchronized samples all
    // disagree with it; a sample is the pin two edges earlier, or 0 near reset.
    always @(posedge clk) begin
        mc = (r1 || r2) ? 4'b0 : p2;
        if (rst) begin
            m_in = '0; m_rise = '0; m_fall = '0; m_pend = '0;
            m_rflip = '0; m_fflip = '0; m_out = 1'b0; m_irqen = 1'b0; m_ack = 1'b0;
            syn_q.delete();
        end else begin
            macc = wb_cyc_i && wb_stb_i && !m_ack;
            if (macc) begin
                case (wb_adr_i[4:2])
                    3'd0:    mrd = {28'b0, m_in};
                    3'd1:    mrd = {31'b0, m_out};
                    3'd2:    mrd = {28'b0, m_rise};
                    3'd3:    mrd = {28'b0, m_fall};
                    3'd4:    mrd = {28'b0, m_pend};
                    3'd5:    mrd = {31'b0, m_irqen};
                    default: mrd = 32'h0;
                endcase
                me.rd = !wb_we_i;
                me.d  = mrd;
                sb.push_back(me);
            end
            mset = (m_rflip & m_rise) | (m_fflip & m_fall);
            mclr = (macc && wb_we_i && wb_adr_i[4:2] == 3'd4) ? wb_dat_i[3:0] : 4'b0;
            m_pend = (m_pend & ~mclr) | mset;
            if (macc && wb_we_i) begin
                case (wb_adr_i[4:2])
                    3'd1:    m_out   = wb_dat_i[0];
                    3'd2:    m_rise  = wb_dat_i[3:0];
                    3'd3:    m_fall  = wb_dat_i[3:0];
                    3'd5:    m_irqen = wb_dat_i[0];
                    default: ;
                endcase
            end
            m_ack = macc;
            syn_q.push_back(mc);
            if (syn_q.size() > c_deb) void'(syn_q.pop_front());
            m_rflip = '0;
            m_fflip = '0;
            if (syn_q.size() == c_deb) begin
                for (int ch = 0; ch < c_nin; ch++) begin
                    mall = 1'b1;
                    for (int j = 0; j < c_deb; j++)
                        if (syn_q[j][ch] == m_in[ch]) mall = 1'b0;
                    if (mall) begin
                        m_in[ch] = ~m_in[ch];
                        if (m_in[ch]) m_rflip[ch] = 1'b1;
                        else          m_fflip[ch] = 1'b1;
                    end
                end
            end
        end
        p2 = p1; p1 = gpio_in;
        r2 = r1; r1 = rst;
    end

    // Monitor: output pins every cycle, bus data whenever an ack is presented
    always @(negedge clk) begin
        check("ack", {31'b0, wb_ack_o}, {31'b0, m_ack});
        check("gpio_out", {31'b0, gpio_out}, {31'b0, m_out});
        check("irq", {31'b0, irq_o}, {31'b0, m_irqen & (|m_pend)});
        if (wb_ack_o) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: ack seen, got 1 expected 0 at %0t", $time);
            end else begin
                me = sb.pop_front();
                if (me.rd) check("rd_data", wb_dat_o, me.d);
            end
        end else begin
            check("dat_idle", wb_dat_o, 32'h0);
        end
    end

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       output logic [31:0] rd);
        int n;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = 4'hF;
        n = 0;
        rd = '0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_ack_o && n < 8);
        if (!wb_ack_o) begin
            tests++;
            fails++;
            $display("FAIL bus_timeout: adr %h got no ack expected ack", adr);
        end else begin
            rd = wb_dat_o;
        end
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        bus(1'b1, adr, dat, dummy);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] d);
        bus(1'b0, adr, 32'h0, d);
    endtask

    initial begin
        logic [31:0] d;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset clears everything
        for (int a = 0; a < 8; a++) wr(32'(a * 4), 32'hFFFF_FFFF);
        gpio_in = 4'hF;
        repeat (12) @(negedge clk);
        check("pre_rst_irq", {31'b0, irq_o}, 32'h1);
        gpio_in = 4'h0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_gpio_out", {31'b0, gpio_out}, 32'h0);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd(32'(a * 4), d);
            check("rst_reg", d, 32'h0);
        end

        // Rising edge: PEND and irq exactly 2+DEBOUNCE+1 edges after the pin
        wr(32'h08, 32'h1);
        wr(32'h14, 32'h1);
        @(negedge clk);
        gpio_in = 4'b0001;
        repeat (6) @(negedge clk);
        check("irq_early", {31'b0, irq_o}, 32'h0);
        @(negedge clk);
        check("irq_set", {31'b0, irq_o}, 32'h1);
        rd(32'h00, d); check("rise_in", d, 32'h1);
        rd(32'h10, d); check("rise_pend", d, 32'h1);
        wr(32'h10, 32'h1);
        check("irq_clr", {31'b0, irq_o}, 32'h0);

        // Glitch rejection then an accepted pulse
        wr(32'h08, 32'hF);
        gpio_in = 4'b0000;
        repeat (10) @(negedge clk);
        wr(32'h10, 32'hF);
        gpio_in = 4'b0010;
        repeat (3) @(negedge clk);
        gpio_in = 4'b0000;
        repeat (10) @(negedge clk);
        rd(32'h00, d); check("glitch_in", d, 32'h0);
        rd(32'h10, d); check("glitch_pend", d, 32'h0);
        gpio_in = 4'b0010;
        repeat (4) @(negedge clk);
        gpio_in = 4'b0000;
        repeat (2) @(negedge clk);
        rd(32'h00, d); check("pulse_in", d, 32'h2);
        rd(32'h10, d); check("pulse_pend", d, 32'h2);

        // Falling edges masked
        repeat (20) @(negedge clk);
        wr(32'h10, 32'hF);
        wr(32'h0C, 32'h0);
        for (int i = 0; i < 4; i++) begin
            gpio_in = 4'(1 << i);
            repeat (100) @(negedge clk);
        end
        rd(32'h10, d); check("fall_mask_pend", d, 32'hF);

        // Clear and set of PEND[2] on the same edge: set wins
        wr(32'h10, 32'hF);
        @(negedge clk);
        gpio_in = 4'b0100;
        repeat (5) @(negedge clk);
        wr(32'h10, 32'h4);
        rd(32'h10, d); check("collision_pend", d, 32'h4);

        // Bus timing and unmapped offset
        wr(32'h04, 32'h1);
        check("out_write", {31'b0, gpio_out}, 32'h1);
        rd(32'h1C, d); check("unmapped_rd", d, 32'h0);

        // Reset in the middle of an access aborts it
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_ack", {31'b0, wb_ack_o}, 32'h0);
        rst = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

        // Reset during debounce; pin held high re-enters after reset
        gpio_in = 4'b0001;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(32'h08, 32'h1);
        repeat (10) @(negedge clk);
        rd(32'h00, d); check("post_rst_in", d, 32'h1);
        rd(32'h10, d); check("post_rst_pend", d, 32'h1);

        // Randomized traffic against the model
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    gpio_in = 4'($urandom);
                    repeat ($urandom_range(1, (k % 4 == 0) ? 20 : 7)) @(negedge clk);
                end
            end
            begin
                logic [31:0] rdv;
                for (int k = 0; k < 150; k++) begin
                    bus(1'($urandom), 32'($urandom_range(0, 7) * 4), $urandom, rdv);
                end
            end
        join
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
